ram_stream_reader: RTL and testbench

- Read-side initiator for the team's synchronous dual-port RAM, which registers its read output and so has 1-cycle read latency.
- On a start command it reads `len` consecutive words from `base_addr`, drives the RAM read address, and absorbs the read latency.
- Words are presented on a valid/ready output stream with full backpressure support.
- Sits between the RAM read port and a downstream consumer such as a UART TX, video or DMA path.

---
 rtl/ram_stream_reader.sv | 151 +++++++++++++++
 tb/tb_ram_stream_reader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Streams len consecutive words out of a 1-cycle-latency synchronous RAM onto a
// valid/ready interface, buffering enough reads in flight to sustain one word per cycle.
module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done_tick,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_INC  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = '0;
    localparam logic [PTR_W:0]        BUF_FULL  = (PTR_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W:0]        COUNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W+1:0]      OCC_LIMIT = (PTR_W + 2)'(BUF_DEPTH);
    localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH:0]   issued_left;
    logic                  accept;
    logic                  issue;
    logic                  push;
    logic                  pop;

    logic                  vld_p0;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] q_p1;

    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        buf_count;
    logic [PTR_W+1:0]      occupancy;

    // Buffered words plus reads still travelling through the RAM and capture stage.
    assign occupancy = {1'b0, buf_count}
                     + {{(PTR_W + 1){1'b0}}, vld_p0}
                     + {{(PTR_W + 1){1'b0}}, vld_p1};

    assign issue     = (state == RUN) && (issued_left != CNT_ZERO) && (occupancy < OCC_LIMIT);
    assign push      = vld_p1;
    assign m_valid   = (buf_count != '0);
    assign pop       = m_valid && m_ready;
    assign m_data    = m_valid ? buf_mem[rd_ptr] : '0;
    assign r_addr    = addr_reg;
    assign busy      = (state != IDLE);
    assign done_tick = (state == DONE);

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (len == CNT_ZERO) ? DONE : RUN;
                end
            end
            RUN: begin
                if ((issue && issued_left == CNT_ONE) || issued_left == CNT_ZERO) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && remaining == CNT_ONE) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr_reg    <= '0;
            remaining   <= '0;
            issued_left <= '0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            buf_count   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_reg    <= base_addr;
                remaining   <= len;
                issued_left <= len;
            end else begin
                if (issue) begin
                    addr_reg    <= addr_reg + ADDR_INC;
                    issued_left <= issued_left - CNT_ONE;
                end
                if (pop) begin
                    remaining <= remaining - CNT_ONE;
                end
            end
            // p0: RAM is presenting the word addressed last cycle; p1: word captured locally.
            vld_p0 <= issue;
            vld_p1 <= vld_p0;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   buf_count <= buf_count + COUNT_ONE;
                2'b01:   buf_count <= buf_count - COUNT_ONE;
                default: buf_count <= buf_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        q_p1 <= ram_q;
        if (push) begin
            buf_mem[wr_ptr] <= q_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push && !pop) begin
            assert (buf_count < BUF_FULL);
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: a registered-output RAM model feeds the DUT and
// every streamed word is compared with the word the RAM array holds at (base + i) mod depth.
module tb_ram_stream_reader;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done_tick;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;

    logic [DW-1:0] ram [DEPTH];

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] got[$];
    logic [AW-1:0] addr_seq[$];
    int            first_valid_k;
    int            done_k;
    int            done_cnt;
    int            last_hs_k;
    int            max_outst;
    int            stall_bad;
    int            busy_bad;
    int            busy_after_done;
    bit            timed_out;

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUF_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done_tick (done_tick),
        .r_addr    (r_addr),
        .ram_q     (ram_q),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= ram[r_addr];

    function automatic logic [DW-1:0] model_word(input logic [AW-1:0] b, input int i);
        return ram[(int'(b) + i) % DEPTH];
    endfunction

    // Drives one command and records what the stream, address and status ports did.
    // k counts cycles after the edge that sampled start (k = 0 is the first such cycle).
    task automatic run_transfer(input logic [AW-1:0] b, input logic [AW:0] n,
                                input int ready_pct, input int budget, input int pulse_k);
        int            k;
        int            issues;
        int            hs_done;
        logic [AW-1:0] prev_addr;
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        bit            fin;
        got.delete();
        addr_seq.delete();
        first_valid_k   = -1;
        done_k          = -1;
        done_cnt        = 0;
        last_hs_k       = -1;
        max_outst       = 0;
        stall_bad       = 0;
        busy_bad        = 0;
        busy_after_done = -1;
        timed_out       = 0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        len       = n;
        @(posedge clk);
        #1;
        start      = 1'b0;
        k          = 0;
        issues     = 0;
        hs_done    = 0;
        prev_addr  = b;
        prev_stall = 1'b0;
        prev_data  = '0;
        fin        = 0;
        addr_seq.push_back(b);
        while (!fin) begin
            if (r_addr !== prev_addr) begin
                issues++;
                addr_seq.push_back(r_addr);
                prev_addr = r_addr;
            end
            if (issues - hs_done > max_outst) max_outst = issues - hs_done;
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) stall_bad++;
            if (k == pulse_k) begin
                start     = 1'b1;
                base_addr = b + 10'd5;
                len       = 11'd3;
            end else begin
                start = 1'b0;
            end
            m_ready = ($urandom_range(99) < ready_pct);
            if (m_valid === 1'b1 && first_valid_k < 0) first_valid_k = k;
            if (done_k < 0 && busy !== 1'b1) busy_bad++;
            if (done_tick === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0 && k == done_k + 1) begin
                busy_after_done = int'(busy);
                fin = 1;
            end
            if (m_valid === 1'b1 && m_ready) begin
                got.push_back(m_data);
                last_hs_k = k;
                hs_done++;
            end
            prev_stall = (m_valid === 1'b1) && !m_ready;
            prev_data  = m_data;
            if (k >= budget) begin
                timed_out = 1;
                fin = 1;
            end
            @(posedge clk);
            #1;
            k++;
        end
        start   = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_tick); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", m_valid); end
        checks++; if (r_addr !== '0) begin errors++; $display("FAIL reset_raddr got %h want 000", r_addr); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_mdata got %h want 00", m_data); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int n_bad = 0;
        run_transfer(10'h010, 11'd4, 100, 100, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got timeout want done_tick"); end
        for (int i = 0; i < got.size(); i++) if (got[i] !== model_word(10'h010, i)) n_bad++;
        checks++; if (got.size() != 4 || n_bad != 0) begin
            errors++; $display("FAIL basic_stream got %0d words (%0d wrong) want 4 words 10..13", got.size(), n_bad);
        end
        checks++; if (first_valid_k != 3) begin errors++; $display("FAIL basic_latency got %0d want 3", first_valid_k); end
        checks++; if (last_hs_k - first_valid_k != 3) begin
            errors++; $display("FAIL basic_consecutive got span %0d want 3", last_hs_k - first_valid_k);
        end
        checks++; if (done_k != last_hs_k + 1 || done_cnt != 1) begin
            errors++; $display("FAIL basic_done got k=%0d cnt=%0d want k=%0d cnt=1", done_k, done_cnt, last_hs_k + 1);
        end
        checks++; if (busy_after_done != 0 || busy_bad != 0) begin
            errors++; $display("FAIL basic_busy got after=%0d bad=%0d want 0 0", busy_after_done, busy_bad);
        end
    endtask

    task automatic test_backpressure();
        int n_bad = 0;
        run_transfer(10'h000, 11'd16, 50, 600, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout got timeout want done_tick"); end
        for (int i = 0; i < got.size(); i++) if (got[i] !== model_word(10'h000, i)) n_bad++;
        checks++; if (got.size() != 16 || n_bad != 0) begin
            errors++; $display("FAIL bp_stream got %0d words (%0d wrong) want 16 words 00..0F", got.size(), n_bad);
        end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stable got %0d unstable stalls want 0", stall_bad); end
        checks++; if (max_outst > 4) begin errors++; $display("FAIL bp_outstanding got %0d want <=4", max_outst); end
        checks++; if (done_k != last_hs_k + 1 || done_cnt != 1) begin
            errors++; $display("FAIL bp_done got k=%0d cnt=%0d want k=%0d cnt=1", done_k, done_cnt, last_hs_k + 1);
        end
    endtask

    task automatic test_wrap();
        int            n_bad = 0;
        int            a_bad = 0;
        logic [AW-1:0] exp_addr;
        run_transfer(10'h3FE, 11'd4, 100, 100, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL wrap_timeout got timeout want done_tick"); end
        for (int i = 0; i < 4; i++) begin
            exp_addr = AW'((10'h3FE + i) % DEPTH);
            if (i >= addr_seq.size() || addr_seq[i] !== exp_addr) a_bad++;
        end
        checks++; if (a_bad != 0) begin
            errors++; $display("FAIL wrap_raddr got %0d wrong addresses want 3FE,3FF,000,001", a_bad);
        end
        for (int i = 0; i < got.size(); i++) if (got[i] !== model_word(10'h3FE, i)) n_bad++;
        checks++; if (got.size() != 4 || n_bad != 0) begin
            errors++; $display("FAIL wrap_stream got %0d words (%0d wrong) want FE,FF,00,01", got.size(), n_bad);
        end
    endtask

    task automatic test_len0();
        run_transfer(10'h123, 11'd0, 100, 20, -1);
        checks++; if (done_k != 0 || done_cnt != 1) begin
            errors++; $display("FAIL len0_done got k=%0d cnt=%0d want k=0 cnt=1", done_k, done_cnt);
        end
        checks++; if (first_valid_k != -1 || got.size() != 0) begin
            errors++; $display("FAIL len0_valid got first=%0d words=%0d want none", first_valid_k, got.size());
        end
        checks++; if (busy_after_done != 0) begin errors++; $display("FAIL len0_busy got %0d want 0", busy_after_done); end
    endtask

    task automatic test_full();
        int n_bad = 0;
        run_transfer(10'h200, 11'd1024, 100, 3000, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL full_timeout got timeout want done_tick"); end
        for (int i = 0; i < got.size(); i++) if (got[i] !== model_word(10'h200, i)) n_bad++;
        checks++; if (got.size() != 1024 || n_bad != 0) begin
            errors++; $display("FAIL full_stream got %0d words (%0d wrong) want 1024", got.size(), n_bad);
        end
        checks++; if (got.size() == 0 || got[$] !== 8'hFF) begin
            errors++; $display("FAIL full_last got %h want FF", (got.size() == 0) ? 8'h00 : got[$]);
        end
        checks++; if (last_hs_k - first_valid_k != 1023) begin
            errors++; $display("FAIL full_throughput got span %0d want 1023", last_hs_k - first_valid_k);
        end
    endtask

    task automatic test_abort();
        int stray = 0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = 10'h040;
        len       = 11'd8;
        m_ready   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (m_valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL abort_prefill got valid=%b busy=%b want 1 1", m_valid, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || done_tick !== 1'b0) begin
            errors++; $display("FAIL abort_state got valid=%b busy=%b done=%b want 0 0 0", m_valid, busy, done_tick);
        end
        @(negedge clk);
        reset   = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (m_valid !== 1'b0 || done_tick !== 1'b0 || busy !== 1'b0) stray++;
        end
        m_ready = 1'b0;
        checks++; if (stray != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", stray); end
        test_basic();
    endtask

    task automatic test_ignored_start();
        int n_bad = 0;
        run_transfer(10'h080, 11'd6, 70, 300, 2);
        checks++; if (timed_out) begin errors++; $display("FAIL ign_timeout got timeout want done_tick"); end
        for (int i = 0; i < got.size(); i++) if (got[i] !== model_word(10'h080, i)) n_bad++;
        checks++; if (got.size() != 6 || n_bad != 0 || done_cnt != 1) begin
            errors++; $display("FAIL ign_stream got %0d words (%0d wrong) %0d dones want 6 0 1", got.size(), n_bad, done_cnt);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] b;
        logic [AW:0]   n;
        int            n_bad;
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
        for (int t = 0; t < 4; t++) begin
            b = AW'($urandom_range(DEPTH - 1));
            n = (AW + 1)'($urandom_range(40, 1));
            run_transfer(b, n, 60, 800, -1);
            n_bad = 0;
            for (int i = 0; i < got.size(); i++) if (got[i] !== model_word(b, i)) n_bad++;
            checks++; if (timed_out || got.size() != int'(n) || n_bad != 0) begin
                errors++; $display("FAIL rand_stream got %0d words (%0d wrong, timeout=%0d) want %0d", got.size(), n_bad, timed_out, n);
            end
            checks++; if (stall_bad != 0 || max_outst > 4 || done_k != last_hs_k + 1) begin
                errors++; $display("FAIL rand_protocol got stalls=%0d outst=%0d done=%0d want 0 <=4 %0d", stall_bad, max_outst, done_k, last_hs_k + 1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        m_ready   = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_len0();
        test_full();
        test_abort();
        test_ignored_start();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
